// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared FSM state and command encodings for rs_flag_arbiter
package rs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Command pair is {set, clr} as sampled from the granted requester
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_CLR = 2'b01;
  localparam logic [1:0] CMD_ILL = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker searching upward from ptr+1
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Visit ptr+1, ptr+2, ... wrapping, so the last winner has lowest priority
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_flag_arbiter.sv
// rtl/rs_flag_arbiter.sv - round-robin set/clear serialiser onto one registered RS flag
// Optional statistics counters are enabled with RS_ARB_STATS_EN.
module rs_flag_arbiter
  import rs_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         set_req,
  input  logic [NUM_REQ-1:0]         clr_req,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic                       q,
  output logic                       q_bar,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
`ifdef RS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]           set_cnt,
  output logic [CNT_W-1:0]           clr_cnt,
  output logic [CNT_W-1:0]           ill_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || SETTLE_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("rs_flag_arbiter: parameter out of range");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [SET_W-1:0]   settle_cnt;
  logic [1:0]         cmd;
  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;

  assign active = set_req | clr_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (active),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= IDX_W'(NUM_REQ - 1);
      settle_cnt <= '0;
      cmd        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      q          <= 1'b0;
      q_bar      <= 1'b1;
      busy       <= 1'b0;
      gnt_id     <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|active) begin
            gnt_id <= win_idx;
            cmd    <= {|(set_req & win_gnt), |(clr_req & win_gnt)};
            busy   <= 1'b1;
            state  <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          case (cmd)
            CMD_SET: begin
              q     <= 1'b1;
              q_bar <= 1'b0;
            end
            CMD_CLR: begin
              q     <= 1'b0;
              q_bar <= 1'b1;
            end
            CMD_ILL: err <= 1'b1;
            default: ;
          endcase
          ack        <= NUM_REQ'(1) << gnt_id;
          ptr        <= gnt_id;
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RS_ARB_STATS_EN
  // Saturating counters, bumped in the APPLY cycle of each command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt <= '0;
      clr_cnt <= '0;
      ill_cnt <= '0;
    end else if (state == ST_APPLY) begin
      if (cmd == CMD_SET && set_cnt != '1) set_cnt <= set_cnt + 1'b1;
      if (cmd == CMD_CLR && clr_cnt != '1) clr_cnt <= clr_cnt + 1'b1;
      if (cmd == CMD_ILL && ill_cnt != '1) ill_cnt <= ill_cnt + 1'b1;
    end
  end
`else
  // Statistics counters and their ports are compiled out.
`endif

endmodule

// File: tb/tb_rs_flag_arbiter.sv
// tb/tb_rs_flag_arbiter.sv - scoreboard bench for rs_flag_arbiter (RS_ARB_STATS_EN optional)
module tb_rs_flag_arbiter;

  localparam int NUM_REQ = 4;
  localparam int SETTLE  = 2;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] set_req = '0;
  logic [NUM_REQ-1:0] clr_req = '0;
  logic [NUM_REQ-1:0] ack;
  logic               err;
  logic               q;
  logic               q_bar;
  logic               busy;
  logic [1:0]         gnt_id;
`ifdef RS_ARB_STATS_EN
  logic [CNT_W-1:0]   set_cnt;
  logic [CNT_W-1:0]   clr_cnt;
  logic [CNT_W-1:0]   ill_cnt;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_e;
  logic       model_q = 1'b0;

  rs_flag_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .ack     (ack),
    .err     (err),
    .q       (q),
    .q_bar   (q_bar),
    .busy    (busy),
    .gnt_id  (gnt_id)
`ifdef RS_ARB_STATS_EN
    ,
    .set_cnt (set_cnt),
    .clr_cnt (clr_cnt),
    .ill_cnt (ill_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected response {ack, err, q, q_bar} for one command, from a tiny flag model
  function automatic void expect_cmd(input int id, input logic s, input logic c);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    if (s && !c) model_q = 1'b1;
    else if (c && !s) model_q = 1'b0;
    exp_q.push_back({oh, s & c, model_q, ~model_q});
  endfunction

  always @(negedge clk) begin
    if (rst_n && (ack != '0 || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {25'b0, ack, err, q, q_bar}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_resp", {25'b0, ack, err, q, q_bar}, {25'b0, mon_e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
  endtask

  task automatic issue(input int id, input logic s, input logic c);
    logic got;
    expect_cmd(id, s, c);
    cyc();
    set_req[id] = s;
    clr_req[id] = c;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ack[id]) got = 1'b1;
    end
    if (!got) chk("ack_timeout", {31'b0, got}, 32'h1);
    cyc();
    set_req[id] = 1'b0;
    clr_req[id] = 1'b0;
    wait_idle();
  endtask

  // Requesters hold their command, drop for one cycle after each ack, then reassert
  task automatic run_rr(input logic [3:0] sp, input logic [3:0] cp, input int n_acks);
    logic [3:0] drop;
    int acks;
    drop = '0;
    acks = 0;
    for (int i = 0; i < 200 && acks < n_acks; i++) begin
      cyc();
      set_req = sp & ~drop;
      clr_req = cp & ~drop;
      @(negedge clk);
      drop = ack;
      if (ack != '0) acks++;
    end
    if (acks < n_acks) chk("rr_timeout", acks, n_acks);
    cyc();
    set_req = '0;
    clr_req = '0;
    wait_idle();
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    model_q = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state held with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_state", {22'b0, q, q_bar, busy, ack, err, gnt_id},
          {22'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'b00});
    end

    // Single set on requester 2: latency and busy window
    expect_cmd(2, 1'b1, 1'b0);
    cyc();
    set_req[2] = 1'b1;
    @(negedge clk); chk("busy_n", busy, 1'b0);
    @(negedge clk); chk("busy_n1", busy, 1'b1);
    @(negedge clk); chk("busy_n2", busy, 1'b1);
    chk("ack_n2", {ack, q}, {4'b0100, 1'b1});
    cyc();
    set_req[2] = 1'b0;
    @(negedge clk); chk("busy_n3", busy, 1'b1);
    @(negedge clk); chk("busy_n4", busy, 1'b0);
    chk("gnt_id_2", gnt_id, 2'd2);

    issue(2, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0);
    issue(0, 1'b1, 1'b1);
    chk("q_after_illegal", {q, q_bar}, 2'b10);
`ifdef RS_ARB_STATS_EN
    chk("cnt_after_illegal", {set_cnt, clr_cnt, ill_cnt}, {2'd2, 2'd1, 2'd1});
`endif

    // Fairness: 0 set, 1 clr, 3 set held continuously from a fresh reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      expect_cmd(0, 1'b1, 1'b0);
      expect_cmd(1, 1'b0, 1'b1);
      expect_cmd(3, 1'b1, 1'b0);
    end
    run_rr(4'b1001, 4'b0010, 6);

    // Reset during SETTLE after a set on requester 1
    expect_cmd(1, 1'b1, 1'b0);
    cyc();
    set_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("ack_before_reset", ack, 4'b0010);
    cyc();
    set_req[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out", {ack, q, q_bar, busy}, {4'b0000, 1'b0, 1'b1, 1'b0});
    model_q = 1'b0;
    cyc();
    rst_n = 1'b1;
    expect_cmd(0, 1'b1, 1'b0);
    expect_cmd(2, 1'b1, 1'b0);
    run_rr(4'b0101, 4'b0000, 2);

    // Three more sets make five since reset
    for (int i = 0; i < 3; i++) issue(1, 1'b1, 1'b0);
`ifdef RS_ARB_STATS_EN
    chk("cnt_saturate", {set_cnt, clr_cnt, ill_cnt}, {2'd3, 2'd0, 2'd0});
`endif

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_flag_arbiter.md
# rs_flag_arbiter

Shared-flag controller that serialises set/clear commands from `NUM_REQ` requesters onto a single RS-style status flag. Requests are granted round-robin, one command at a time. Each command is applied to a registered `q`/`q_bar` pair and acknowledged. A programmable settle window follows each update before the next grant. Sits between multiple control agents and any logic that consumes one shared set/reset status bit.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `SETTLE_CYCLES`, 2: hold-off cycles after each applied command, ≥1.
- `CNT_W`, 8: width of statistics counters, used only with the stats macro.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `set_req`  in  NUM_REQ  per-requester set command; held until its `ack`.
- `clr_req`  in  NUM_REQ  per-requester clear command; held until its `ack`.
- `ack`  out  NUM_REQ  one-cycle acknowledge to the granted requester.
- `err`  out  1  one-cycle pulse, coincident with `ack`, when the granted command was illegal.
- `q`  out  1  shared flag.
- `q_bar`  out  1  always `~q`.
- `busy`  out  1  high while a command is being applied or settling.
- `gnt_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `set_cnt`, `clr_cnt`, `ill_cnt`  out  CNT_W each  statistics counters; present only with `RS_ARB_STATS_EN`.

## Operation
- **Active request:** requester i is active when `set_req[i] | clr_req[i]`.
- **FSM states:** IDLE, APPLY, SETTLE.
- **IDLE**
  - If no requester is active, stay in IDLE.
  - Otherwise pick round-robin, searching upward from `ptr+1` with wrap. Capture the winner's index and its {set,clr} pair, then go to APPLY.
- **APPLY** (exactly 1 cycle), command decode:
  - set-only: `q`←1.
  - clr-only: `q`←0.
  - both set and clr: `q` unchanged, `err` pulsed, counted as illegal.
  - In all cases register `ack[id]`←1, set `ptr`←id, load the settle counter, go to SETTLE.
- **SETTLE:** lasts SETTLE_CYCLES cycles, then return to IDLE. Requests are not sampled in this state.
- **Captured commands are committed.** A request dropped after capture is still applied and acknowledged.
- **Requester rule:** deassert the request in the cycle after `ack`. A request still high when the FSM re-enters IDLE is treated as a new command.
- **Requester changes its command while waiting:** the value sampled in the IDLE capture cycle wins.
- **Reset values:** `q`=0, `q_bar`=1, `ack`=0, `err`=0, `busy`=0, `gnt_id`=0, `ptr`=NUM_REQ-1 (requester 0 has first priority), FSM in IDLE, counters 0.
- **Reset mid-operation:** asynchronously abandons the command. No `ack`; `q` returns to 0.

## Timing
- Request seen in IDLE at cycle n:
  - APPLY in cycle n+1.
  - `ack`, `err` and the new `q` are all visible in cycle n+2, the first SETTLE cycle.
  - IDLE again in cycle n+2+SETTLE_CYCLES.
- Throughput: one command per 2+SETTLE_CYCLES cycles when requests are back-to-back.
- `busy` is high in APPLY and SETTLE, low in IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.
- `ack` is one-hot or zero. `err` is high only when `ack` is nonzero.
- Fairness: each continuously active requester is served within NUM_REQ grants.

## Configuration
- **Macro:** `RS_ARB_STATS_EN`.
- **Defined:**
  - `set_cnt`, `clr_cnt` and `ill_cnt` increment in the APPLY cycle for set-only, clr-only and illegal commands respectively.
  - The counters saturate at all-ones and clear only on reset.
- **Undefined:** the counters and their ports are absent. All other behaviour is identical.

## Structure
- **Shared package `rs_pkg`:** the FSM state enum (IDLE/APPLY/SETTLE) and the command encoding (CMD_SET=2'b10, CMD_CLR=2'b01, CMD_ILL=2'b11).
- **Sub-module `rr_arbiter`:**
  - Parameterised round-robin picker over NUM_REQ.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant and binary index.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- After reset, hold all requests low → `q`=0, `q_bar`=1, `busy`=0, `ack`=0 for 10 cycles.
- `set_req[2]`=1 at cycle n with SETTLE_CYCLES=2 → `ack`=4'b0100 and `q`=1 at n+2; `busy` high n+1..n+3; IDLE at n+4.
- `set_req[0]` and `clr_req[0]` both high → `err`=1 with `ack[0]`, `q` unchanged, `ill_cnt`=1 when stats are enabled.
- Requests 0, 1 and 3 held continuously, each dropping for one cycle after its `ack` → grant order 0,1,3,0,1,3, with no requester starved.
- `rst_n` pulsed low during SETTLE after a set → `q` returns to 0 immediately, no further `ack`, and requester 0 is granted first afterwards.
- Stats enabled with CNT_W=2, five set commands → `set_cnt` saturates at 3.
